act_max_buffer: RTL

//  Upstream stage of the quantizer. Buffers one tile of fp32 activations and tracks the running max magnitude.

---
 rtl/act_pkg.sv | 23 ++
 rtl/act_tile_ram.sv | 33 +++
 rtl/act_max_buffer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/act_pkg.sv
// Shared fp32 field constants, helpers and FSM state type for the activation max buffer.
package act_pkg;

  localparam int          FP32_EXP_MSB  = 30;
  localparam int          FP32_EXP_LSB  = 23;
  localparam logic [7:0]  FP32_EXP_ALL1 = 8'hFF;
  localparam logic [30:0] FP32_MAG_MASK = 31'h7FFFFFFF;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // All-ones exponent marks both NaN and Inf encodings.
  function automatic logic is_nan_inf(input logic [31:0] word);
    return word[FP32_EXP_MSB:FP32_EXP_LSB] == FP32_EXP_ALL1;
  endfunction

  function automatic logic [30:0] fp32_mag(input logic [31:0] word);
    return word[30:0] & FP32_MAG_MASK;
  endfunction

endpackage

// File: rtl/act_tile_ram.sv
// Single-tile activation store: one write port, one registered read port with write-through forwarding.
module act_tile_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A one-word tile reads address 0 on the same edge it is written, so forward the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/act_max_buffer.sv
// Buffers one fp32 tile while tracking its max magnitude, then replays it paired with that max.
// Optional NaN/Inf filtering is enabled by defining ACT_MAX_NAN_FILTER_EN.
module act_max_buffer
  import act_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_act_valid,
  output logic              o_act_ready,
  input  logic [DATA_W-1:0] i_act_data,
  input  logic              i_act_last,
  output logic              o_q_valid,
  input  logic              i_q_ready,
  output logic [DATA_W-1:0] o_q_activation,
  output logic [DATA_W-1:0] o_q_max,
  output logic              o_q_last,
  output logic              o_nan_seen
);

  localparam int CNT_W = $clog2(DEPTH);

  state_t state_q, state_d;

  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  rd_addr;
  logic [CNT_W-1:0]  last_idx;
  logic [30:0]       max_q;
  logic [30:0]       max_next;
  logic [30:0]       store_mag;
  logic [DATA_W-1:0] store_word;
  logic [DATA_W-1:0] q_max_q;
  logic              q_valid_q;
  logic              q_last_q;

  logic              act_hs;
  logic              tile_end;
  logic              drain_end;
  logic              ram_re;
  logic [CNT_W-1:0]  ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign o_act_ready = (state_q == ST_FILL);
  assign act_hs      = i_act_valid && o_act_ready;

`ifdef ACT_MAX_NAN_FILTER_EN
  logic nan_in;
  logic nan_seen_q;

  assign nan_in     = is_nan_inf(i_act_data);
  assign store_word = nan_in ? '0 : i_act_data;
  assign o_nan_seen = nan_seen_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nan_seen_q <= 1'b0;
    end else if (act_hs && nan_in) begin
      nan_seen_q <= 1'b1;
    end
  end
`else
  assign store_word = i_act_data;
  assign o_nan_seen = 1'b0;
`endif

  // Strict greater-than so equal magnitudes keep the incumbent.
  assign store_mag = fp32_mag(store_word);
  assign max_next  = (store_mag > max_q) ? store_mag : max_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tile_end  = 1'b0;
    drain_end = 1'b0;
    ram_re    = 1'b0;
    ram_raddr = rd_addr;
    case (state_q)
      ST_FILL: begin
        if (i_act_valid && (i_act_last || (wr_cnt == CNT_W'(DEPTH - 1)))) begin
          tile_end  = 1'b1;
          ram_re    = 1'b1;
          ram_raddr = '0;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (q_valid_q && i_q_ready) begin
          if (q_last_q) begin
            drain_end = 1'b1;
            state_d   = ST_FILL;
          end else begin
            ram_re = 1'b1;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_cnt <= '0;
      max_q  <= '0;
    end else if (act_hs) begin
      wr_cnt <= tile_end ? '0 : wr_cnt + CNT_W'(1);
      max_q  <= tile_end ? '0 : max_next;
    end
  end

  // The read port is the output register: stalling simply withholds the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr   <= '0;
      last_idx  <= '0;
      q_max_q   <= '0;
      q_valid_q <= 1'b0;
      q_last_q  <= 1'b0;
    end else if (tile_end) begin
      rd_addr   <= CNT_W'(1);
      last_idx  <= wr_cnt;
      q_max_q   <= {1'b0, max_next};
      q_valid_q <= 1'b1;
      q_last_q  <= (wr_cnt == '0);
    end else if (drain_end) begin
      q_max_q   <= '0;
      q_valid_q <= 1'b0;
      q_last_q  <= 1'b0;
    end else if (ram_re) begin
      rd_addr  <= rd_addr + CNT_W'(1);
      q_last_q <= (rd_addr == last_idx);
    end
  end

  act_tile_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_tile_ram (
    .clk   (clk),
    .reset (reset),
    .we    (act_hs),
    .waddr (wr_cnt),
    .wdata (store_word),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign o_q_valid      = q_valid_q;
  assign o_q_activation = ram_rdata;
  assign o_q_max        = q_max_q;
  assign o_q_last       = q_last_q;

endmodule
